// File: rtl/symbolic_qkd_sift_collector.sv
`default_nettype none
// ============================================================================
// symbolic_qkd_sift_collector
//   Drives the symbolic QKD register through arm/measure attempts and sifts
//   released bytes into a key word. Optional macro: QKD_PAD_CHECK_EN.
//   Revision: 1.0
// ============================================================================
module symbolic_qkd_sift_collector #(
  parameter int         KEY_BYTES    = 4,
  parameter logic [3:0] AUTH_ID      = 4'hA,
  parameter int         MAX_ATTEMPTS = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [1:0]             basis_guess,
  input  logic [1:0]             phase_guess,
  input  logic [7:0]             time_now,
  output logic                   reg_init,
  output logic                   reg_read,
  output logic [1:0]             reg_basis,
  output logic [1:0]             reg_phase,
  output logic [3:0]             reg_identity,
  output logic [7:0]             reg_time,
  input  logic [7:0]             reg_value,
  input  logic                   reg_oe,
  input  logic                   reg_pad_en,
  output logic [8*KEY_BYTES-1:0] key_data,
  output logic                   key_valid,
  input  logic                   key_ready,
  output logic                   busy,
  output logic [7:0]             attempt_count,
  output logic [7:0]             fail_count,
  output logic                   abort
);

  localparam int               IDX_W     = $clog2(KEY_BYTES + 1);
  localparam int               KEY_W     = 8 * KEY_BYTES;
  localparam logic [IDX_W-1:0] IDX_FULL  = IDX_W'(KEY_BYTES);
  localparam logic [7:0]       ATT_LIMIT = 8'(MAX_ATTEMPTS);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_INIT   = 3'd1,
    S_SETTLE = 3'd2,
    S_READ   = 3'd3,
    S_EVAL   = 3'd4,
    S_DONE   = 3'd5,
    S_ABORT  = 3'd6
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       guess_q, guess_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [7:0]       cap_q, cap_d;
  logic             hit_q, hit_d;
  logic             tamper_q, tamper_d;
  logic [7:0]       att_q, att_d;
  logic [7:0]       fail_q, fail_d;
  logic             abort_q, abort_d;
  logic             reg_init_q, reg_init_d;
  logic             reg_read_q, reg_read_d;
  logic             key_valid_q, key_valid_d;
  logic             busy_q, busy_d;

  logic             hit_now;
  logic             tamper_now;
  logic [7:0]       att_inc;
  logic [7:0]       fail_inc;
  logic [IDX_W-1:0] idx_inc;

`ifdef QKD_PAD_CHECK_EN
  assign hit_now    = reg_oe && reg_pad_en;
  assign tamper_now = reg_oe && !reg_pad_en;
`else
  logic unused_pad;
  assign unused_pad = reg_pad_en;
  assign hit_now    = reg_oe;
  assign tamper_now = 1'b0;
`endif

  assign att_inc  = (att_q  == 8'hFF) ? att_q  : att_q  + 8'd1;
  assign fail_inc = (fail_q == 8'hFF) ? fail_q : fail_q + 8'd1;
  assign idx_inc  = idx_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    guess_d  = guess_q;
    idx_d    = idx_q;
    key_d    = key_q;
    cap_d    = cap_q;
    hit_d    = hit_q;
    tamper_d = tamper_q;
    att_d    = att_q;
    fail_d   = fail_q;
    abort_d  = abort_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          guess_d  = {basis_guess, phase_guess};
          att_d    = 8'd0;
          fail_d   = 8'd0;
          idx_d    = '0;
          key_d    = '0;
          abort_d  = 1'b0;
          state_d  = S_INIT;
        end
      end
      S_INIT:   state_d = S_SETTLE;
      S_SETTLE: state_d = S_READ;
      S_READ: begin
        hit_d    = hit_now;
        tamper_d = tamper_now;
        cap_d    = reg_value;
        state_d  = S_EVAL;
      end
      S_EVAL: begin
        att_d = att_inc;
        if (hit_q) begin
          for (int b = 0; b < KEY_BYTES; b++) begin
            if (idx_q == IDX_W'(b)) key_d[8*b +: 8] = cap_q;
          end
          idx_d = idx_inc;
        end else begin
          fail_d  = fail_inc;
          guess_d = guess_q + 4'd1;
        end
        // A completing hit wins even on the last budgeted attempt.
        if (hit_q && (idx_inc == IDX_FULL)) state_d = S_DONE;
        else if (tamper_q)                  state_d = S_ABORT;
        else if (att_inc >= ATT_LIMIT)      state_d = S_ABORT;
        else                                state_d = S_INIT;
      end
      S_DONE: begin
        if (key_ready) begin
          key_d   = '0;
          state_d = S_IDLE;
        end
      end
      S_ABORT:  state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    // Entering ABORT zeroizes the partial key and raises the sticky flag.
    if (state_d == S_ABORT) begin
      key_d   = '0;
      abort_d = 1'b1;
    end

    reg_init_d  = (state_d == S_INIT);
    reg_read_d  = (state_d == S_READ);
    key_valid_d = (state_d == S_DONE);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      guess_q     <= 4'd0;
      idx_q       <= '0;
      key_q       <= '0;
      cap_q       <= 8'd0;
      hit_q       <= 1'b0;
      tamper_q    <= 1'b0;
      att_q       <= 8'd0;
      fail_q      <= 8'd0;
      abort_q     <= 1'b0;
      reg_init_q  <= 1'b0;
      reg_read_q  <= 1'b0;
      key_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      guess_q     <= guess_d;
      idx_q       <= idx_d;
      key_q       <= key_d;
      cap_q       <= cap_d;
      hit_q       <= hit_d;
      tamper_q    <= tamper_d;
      att_q       <= att_d;
      fail_q      <= fail_d;
      abort_q     <= abort_d;
      reg_init_q  <= reg_init_d;
      reg_read_q  <= reg_read_d;
      key_valid_q <= key_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign reg_init      = reg_init_q;
  assign reg_read      = reg_read_q;
  assign reg_basis     = guess_q[3:2];
  assign reg_phase     = guess_q[1:0];
  assign reg_identity  = AUTH_ID;
  assign reg_time      = time_now;
  assign key_data      = key_q;
  assign key_valid     = key_valid_q;
  assign busy          = busy_q;
  assign attempt_count = att_q;
  assign fail_count    = fail_q;
  assign abort         = abort_q;

endmodule
`default_nettype wire

// File: tb/tb_symbolic_qkd_sift_collector.sv
`default_nettype none
// Bench for symbolic_qkd_sift_collector: two instances (KEY_BYTES=1 and 4)
// driven against a simple symbolic-register model and an attempt-level model.
module tb_symbolic_qkd_sift_collector;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start1 = 1'b0, start4 = 1'b0;
  logic [1:0] bg = 2'd0, pg = 2'd0;
  logic [7:0] time_now = 8'd50;
  logic       key_ready = 1'b0;
  logic       tamper_en = 1'b0;
  logic [1:0] tag_b = 2'd2, tag_p = 2'd1;
  logic [7:0] vals [0:3];

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT 1 (KEY_BYTES=1)
  logic       init1, rd1, oe1, pe1, kv1, busy1, ab1;
  logic [1:0] b1, p1, rel1;
  logic [3:0] id1;
  logic [7:0] t1, v1, key1, ac1, fc1;
  logic       tused1;
  // DUT 4 (KEY_BYTES=4)
  logic       init4, rd4, oe4, pe4, kv4, busy4, ab4;
  logic [1:0] b4, p4, rel4;
  logic [3:0] id4;
  logic [7:0] t4, v4, ac4, fc4;
  logic [31:0] key4;
  logic       tused4;

  symbolic_qkd_sift_collector #(.KEY_BYTES(1), .AUTH_ID(4'hA), .MAX_ATTEMPTS(16)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .basis_guess(bg), .phase_guess(pg),
    .time_now(time_now), .reg_init(init1), .reg_read(rd1), .reg_basis(b1), .reg_phase(p1),
    .reg_identity(id1), .reg_time(t1), .reg_value(v1), .reg_oe(oe1), .reg_pad_en(pe1),
    .key_data(key1), .key_valid(kv1), .key_ready(key_ready), .busy(busy1),
    .attempt_count(ac1), .fail_count(fc1), .abort(ab1));

  symbolic_qkd_sift_collector #(.KEY_BYTES(4), .AUTH_ID(4'hA), .MAX_ATTEMPTS(16)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .basis_guess(bg), .phase_guess(pg),
    .time_now(time_now), .reg_init(init4), .reg_read(rd4), .reg_basis(b4), .reg_phase(p4),
    .reg_identity(id4), .reg_time(t4), .reg_value(v4), .reg_oe(oe4), .reg_pad_en(pe4),
    .key_data(key4), .key_valid(kv4), .key_ready(key_ready), .busy(busy4),
    .attempt_count(ac4), .fail_count(fc4), .abort(ab4));

  // Symbolic register: releases the next value only on a read with matching tags in the time window.
  assign oe1 = rd1 && (b1 == tag_b) && (p1 == tag_p) && (time_now >= 8'd10) && (time_now <= 8'd200);
  assign oe4 = rd4 && (b4 == tag_b) && (p4 == tag_p) && (time_now >= 8'd10) && (time_now <= 8'd200);
  assign v1  = vals[rel1];
  assign v4  = vals[rel4];
  assign pe1 = oe1 && !(tamper_en && !tused1);
  assign pe4 = oe4 && !(tamper_en && !tused4);

  always @(posedge clk) begin
    if (reset) begin
      rel1 <= 2'd0; rel4 <= 2'd0; tused1 <= 1'b0; tused4 <= 1'b0;
    end else begin
      if (rd1 && oe1) begin rel1 <= rel1 + 2'd1; tused1 <= 1'b1; end
      if (rd4 && oe4) begin rel4 <= rel4 + 2'd1; tused4 <= 1'b1; end
    end
  end

  // Output mux for the instance under test
  logic        sel = 1'b0;
  logic        s_init, s_read, s_kv, s_busy, s_ab;
  logic [3:0]  s_guess, s_id;
  logic [7:0]  s_t, s_ac, s_fc;
  logic [31:0] s_key;
  assign s_init  = sel ? init4 : init1;
  assign s_read  = sel ? rd4 : rd1;
  assign s_kv    = sel ? kv4 : kv1;
  assign s_busy  = sel ? busy4 : busy1;
  assign s_ab    = sel ? ab4 : ab1;
  assign s_guess = sel ? {b4, p4} : {b1, p1};
  assign s_id    = sel ? id4 : id1;
  assign s_t     = sel ? t4 : t1;
  assign s_ac    = sel ? ac4 : ac1;
  assign s_fc    = sel ? fc4 : fc1;
  assign s_key   = sel ? key4 : {24'h0, key1};

  int total = 0;
  int bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Attempt-level model of one run
  int          m_A, m_F;
  bit          m_abort;
  logic [31:0] m_key;
  logic [3:0]  m_guess [1:256];

  task automatic model_run(input logic [3:0] g0, input int kb, input bit tamper);
    logic [3:0] g = g0;
    int idx = 0;
    bit hit;
    bit time_ok = (time_now >= 10) && (time_now <= 200);
    m_A = 0; m_F = 0; m_abort = 0; m_key = 32'h0;
    forever begin
      m_A++;
      m_guess[m_A] = g;
      hit = time_ok && (g == {tag_b, tag_p});
`ifdef QKD_PAD_CHECK_EN
      if (tamper && m_A == 1 && hit) begin m_F++; m_abort = 1; break; end
`endif
      if (hit) begin
        m_key[8*idx +: 8] = vals[idx];
        idx++;
        if (idx == kb) break;
      end else begin
        m_F++;
        g = g + 4'd1;
      end
      if (m_A >= 16) begin m_abort = 1; break; end
    end
    if (m_abort) m_key = 32'h0;
    if (tamper) m_key = m_key; // tamper only changes outcome with pad checking
  endtask

  // Per-cycle comparison against the model while a run is tracked
  bit chk_on = 1'b0;
  int chk_p  = 0;
  always @(negedge clk) begin
    int off, ph, k;
    if (chk_on) begin
      off = cyc - chk_p;
      check("identity", s_id, 4'hA);
      check("time_pass", s_t, time_now);
      if (off >= 1 && off <= 4*m_A) begin
        ph = (off - 1) % 4;
        k  = (off - 1) / 4 + 1;
        check("init_pulse", s_init, ph == 0);
        check("read_pulse", s_read, ph == 2);
        check("busy_run", s_busy, 1);
        check("kv_run", s_kv, 0);
        check("abort_run", s_ab, 0);
        check("attempts_run", s_ac, k - 1);
        if (ph == 2) check("guess", s_guess, m_guess[k]);
      end else if (off == 4*m_A + 1) begin
        check("kv_end", s_kv, !m_abort);
        check("abort_end", s_ab, m_abort);
        check("busy_end", s_busy, 1);
        check("attempts_end", s_ac, m_A);
        check("fails_end", s_fc, m_F);
        check("key_end", s_key, m_key);
        check("init_end", s_init, 0);
      end else if (off == 4*m_A + 2 && m_abort) begin
        check("busy_after_abort", s_busy, 0);
        check("abort_sticky", s_ab, 1);
      end
    end
  end

  task automatic do_reset();
    chk_on = 1'b0;
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
  endtask

  // Start a run; returns at the negedge of cycle offset 1.
  task automatic launch(input bit s, input logic [1:0] b, input logic [1:0] p,
                        input logic [7:0] t, input bit tamper);
    sel = s; bg = b; pg = p; time_now = t; tamper_en = tamper;
    model_run({b, p}, s ? 4 : 1, tamper);
    @(negedge clk);
    if (s) start4 = 1'b1; else start1 = 1'b1;
    chk_p = cyc; chk_on = 1'b1;
    @(negedge clk);
    start1 = 1'b0; start4 = 1'b0;
  endtask

  task automatic check_idle(input string nm);
    check({nm, "_init"}, s_init, 0);
    check({nm, "_read"}, s_read, 0);
    check({nm, "_busy"}, s_busy, 0);
    check({nm, "_kv"}, s_kv, 0);
    check({nm, "_key"}, s_key, 0);
  endtask

  initial begin
    vals[0] = 8'h3C; vals[1] = 8'h3C; vals[2] = 8'h3C; vals[3] = 8'h3C;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      sel = i[0]; #1;
      check_idle("rst");
      check("rst_ac", s_ac, 0);
      check("rst_fc", s_fc, 0);
      check("rst_abort", s_ab, 0);
      check("rst_id", s_id, 4'hA);
      check("rst_time", s_t, 8'd50);
      check("rst_guess", s_guess, 0);
    end

    // Correct guess, one byte: key after 5 cycles; start coinciding with ready in DONE is ignored
    do_reset();
    launch(0, 2'd2, 2'd1, 8'd50, 0);
    repeat (4*m_A) @(negedge clk);
    check("t1_kv", s_kv, 1);
    check("t1_key", s_key, 32'h3C);
    check("t1_ac", s_ac, 1);
    check("t1_fc", s_fc, 0);
    chk_on = 1'b0;
    key_ready = 1'b1; start1 = 1'b1;
    @(negedge clk);
    key_ready = 1'b0; start1 = 1'b0;
    check_idle("t1_hs");
    repeat (8) begin
      @(negedge clk);
      check("t1_norun_init", s_init, 0);
      check("t1_norun_busy", s_busy, 0);
    end

    // Time outside window: budget exhausted
    do_reset();
    launch(0, 2'd0, 2'd0, 8'd5, 0);
    repeat (4*m_A) @(negedge clk);
    check("t3_abort", s_ab, 1);
    check("t3_ac", s_ac, 16);
    check("t3_fc", s_fc, 16);
    check("t3_key", s_key, 0);
    repeat (4) @(negedge clk);
    check("t3_abort_hold", s_ab, 1);
    check("t3_busy", s_busy, 0);
    chk_on = 1'b0;

    // Guess stepping 0..9 without reset: also shows abort cleared by start
    launch(0, 2'd0, 2'd0, 8'd50, 0);
    check("t2_abort_clr", s_ab, 0);
    repeat (4*m_A) @(negedge clk);
    check("t2_latency_kv", s_kv, 1);
    check("t2_ac", s_ac, 10);
    check("t2_fc", s_fc, 9);
    check("t2_key", s_key, 32'h3C);
    chk_on = 1'b0;
    key_ready = 1'b1;
    @(negedge clk);
    key_ready = 1'b0;
    check_idle("t2_hs");

    // Four bytes, back-pressured handoff
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
    do_reset();
    launch(1, 2'd2, 2'd1, 8'd50, 0);
    repeat (4*m_A) @(negedge clk);
    check("t4_key", s_key, 32'h44332211);
    check("t4_ac", s_ac, 4);
    chk_on = 1'b0;
    repeat (10) begin
      @(negedge clk);
      check("t4_hold_kv", s_kv, 1);
      check("t4_hold_key", s_key, 32'h44332211);
    end
    key_ready = 1'b1;
    @(negedge clk);
    key_ready = 1'b0;
    check_idle("t4_hs");

    // Reset during second attempt's SETTLE
    vals[0] = 8'h3C;
    do_reset();
    launch(0, 2'd0, 2'd0, 8'd50, 0);
    repeat (5) @(negedge clk);
    chk_on = 1'b0;
    check("t5_settle_busy", s_busy, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (12) begin
      check("t5_no_read", s_read, 0);
      check("t5_no_init", s_init, 0);
      check("t5_busy", s_busy, 0);
      @(negedge clk);
    end
    check("t5_ac", s_ac, 0);
    check("t5_fc", s_fc, 0);
    check("t5_key", s_key, 0);

    // Output enable without pad enable on the first read
    do_reset();
    launch(0, 2'd2, 2'd1, 8'd50, 1);
    repeat (4*m_A) @(negedge clk);
`ifdef QKD_PAD_CHECK_EN
    check("t6_abort", s_ab, 1);
    check("t6_fc", s_fc, 1);
    check("t6_ac", s_ac, 1);
    check("t6_key", s_key, 0);
    @(negedge clk);
    check("t6_busy", s_busy, 0);
`else
    check("t6_kv", s_kv, 1);
    check("t6_key", s_key, 32'h3C);
    check("t6_fc", s_fc, 0);
    key_ready = 1'b1;
    @(negedge clk);
    key_ready = 1'b0;
`endif
    chk_on = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
